// File: rtl/alu_pkg.sv
// Shared types and constants for the ALU command issuer: opcodes, FSM states,
// flag layout and the flag helper used when capturing non-multiply results.
package alu_pkg;

  localparam int DATA_W     = 16;
  localparam int FLAG_W     = 2;
  localparam int FLAG_CB    = 0;  // carry (ADD) / borrow (SUB) / product-high-nonzero (MUL)
  localparam int FLAG_OVF   = 1;  // signed overflow
  localparam int MUL_CYCLES = 16;

  typedef enum logic [2:0] {
    OP_ADD = 3'b000,
    OP_SUB = 3'b001,
    OP_AND = 3'b010,
    OP_OR  = 3'b011,
    OP_XOR = 3'b100,
    OP_NOT = 3'b101,
    OP_MUL = 3'b110,
    OP_ILL = 3'b111
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_MUL,
    ST_RESP
  } state_e;

  function automatic logic [FLAG_W-1:0] alu_flags(input op_e op,
                                                  input logic [DATA_W-1:0] a,
                                                  input logic [DATA_W-1:0] b);
    logic [DATA_W:0]   sum;
    logic [DATA_W-1:0] diff;
    logic [FLAG_W-1:0] f;
    sum  = {1'b0, a} + {1'b0, b};
    diff = a - b;
    f    = '0;
    case (op)
      OP_ADD: begin
        f[FLAG_OVF] = (a[DATA_W-1] == b[DATA_W-1]) && (sum[DATA_W-1] != a[DATA_W-1]);
        f[FLAG_CB]  = sum[DATA_W];
      end
      OP_SUB: begin
        f[FLAG_OVF] = (a[DATA_W-1] != b[DATA_W-1]) && (diff[DATA_W-1] != a[DATA_W-1]);
        f[FLAG_CB]  = (a < b);
      end
      default: f = '0;
    endcase
    return f;
  endfunction

endpackage

// File: rtl/alu_cmd_fifo.sv
// Generic show-ahead FIFO, registered count; one-cycle write-to-read latency.
// push_rdy drops when full; no pass-through on full even if a pop happens.
module alu_cmd_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_vld,
  output logic             push_rdy,
  input  logic [WIDTH-1:0] push_dat,
  output logic             pop_vld,
  input  logic             pop_rdy,
  output logic [WIDTH-1:0] pop_dat
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PTR_W:0] FULL_CNT = PTR_W'(DEPTH) == '0 ? (PTR_W+1)'(DEPTH) : (PTR_W+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W:0]   count;
  logic             do_push;
  logic             do_pop;

  assign push_rdy = (count != FULL_CNT);
  assign pop_vld  = (count != '0);
  assign pop_dat  = mem[rd_ptr];
  assign do_push  = push_vld && push_rdy;
  assign do_pop   = pop_rdy && pop_vld;

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_dat;
  end

  // Depth is a power of two, so pointers wrap by natural overflow.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (PTR_W+1)'(1);
        2'b01:   count <= count - (PTR_W+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/alu_issuer.sv
// Queues ALU commands and issues them one at a time to an external combinational ALU;
// rsp_valid 3 cycles after push (19 for MUL), held until rsp_ready; cmd_ready = FIFO not full.
module alu_issuer
  import alu_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int TAG_W      = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [2:0]        cmd_opcode,
  input  logic [15:0]       cmd_a,
  input  logic [15:0]       cmd_b,
  input  logic [TAG_W-1:0]  cmd_tag,
  output logic [15:0]       alu_a,
  output logic [15:0]       alu_b,
  output logic [2:0]        alu_opcode,
  input  logic [15:0]       alu_result,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [15:0]       rsp_result,
  output logic [1:0]        rsp_flags,
  output logic [TAG_W-1:0]  rsp_tag,
  output logic              rsp_err,
  output logic              busy
);

  typedef struct packed {
    logic [2:0]        opcode;
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
    logic [TAG_W-1:0]  tag;
  } cmd_t;

  localparam int CMD_W = $bits(cmd_t);
  localparam int IDX_W = $clog2(MUL_CYCLES);

  state_e             state;
  state_e             state_nxt;
  cmd_t               cmd_dat;
  cmd_t               fifo_dat;
  logic               fifo_rdy;
  logic               fifo_vld;
  logic               push_vld;
  logic               pop_en;
  logic               cap_alu;
  logic               cap_ill;
  logic               mul_start;
  logic               mul_step;
  logic               mul_done;
  logic [TAG_W-1:0]   cur_tag;
  logic [IDX_W-1:0]   mul_idx;
  logic [2*DATA_W-1:0] acc;
  logic [2*DATA_W-1:0] acc_nxt;
  logic [FLAG_W-1:0]  mul_flags;

  assign cmd_dat  = '{opcode: cmd_opcode, a: cmd_a, b: cmd_b, tag: cmd_tag};
  assign cmd_ready = rst_n && fifo_rdy;
  assign push_vld  = cmd_valid && cmd_ready;

  alu_cmd_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (CMD_W)
  ) u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .push_vld (push_vld),
    .push_rdy (fifo_rdy),
    .push_dat (cmd_dat),
    .pop_vld  (fifo_vld),
    .pop_rdy  (pop_en),
    .pop_dat  (fifo_dat)
  );

  assign rsp_valid = (state == ST_RESP);
  assign busy      = fifo_vld || (state != ST_IDLE);

  // One shift-add partial product per cycle, indexed by multiplier bit.
  assign acc_nxt = acc + (alu_b[mul_idx] ? ({{DATA_W{1'b0}}, alu_a} << mul_idx)
                                         : {2*DATA_W{1'b0}});

  always_comb begin
    mul_flags           = '0;
    mul_flags[FLAG_CB]  = |acc_nxt[2*DATA_W-1:DATA_W];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    pop_en    = 1'b0;
    cap_alu   = 1'b0;
    cap_ill   = 1'b0;
    mul_start = 1'b0;
    mul_step  = 1'b0;
    mul_done  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (fifo_vld) begin
          pop_en    = 1'b1;
          state_nxt = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        case (op_e'(alu_opcode))
          OP_MUL: begin
            mul_start = 1'b1;
            state_nxt = ST_MUL;
          end
          OP_ILL: begin
            cap_ill   = 1'b1;
            state_nxt = ST_RESP;
          end
          default: begin
            cap_alu   = 1'b1;
            state_nxt = ST_RESP;
          end
        endcase
      end
      ST_MUL: begin
        mul_step = 1'b1;
        if (mul_idx == IDX_W'(MUL_CYCLES - 1)) begin
          mul_done  = 1'b1;
          state_nxt = ST_RESP;
        end
      end
      ST_RESP: begin
        if (rsp_ready) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      alu_a      <= '0;
      alu_b      <= '0;
      alu_opcode <= '0;
      cur_tag    <= '0;
      acc        <= '0;
      mul_idx    <= '0;
      rsp_result <= '0;
      rsp_flags  <= '0;
      rsp_tag    <= '0;
      rsp_err    <= 1'b0;
    end else begin
      if (pop_en) begin
        alu_a      <= fifo_dat.a;
        alu_b      <= fifo_dat.b;
        alu_opcode <= fifo_dat.opcode;
        cur_tag    <= fifo_dat.tag;
      end
      if (cap_alu) begin
        rsp_result <= alu_result;
        rsp_flags  <= alu_flags(op_e'(alu_opcode), alu_a, alu_b);
        rsp_tag    <= cur_tag;
        rsp_err    <= 1'b0;
      end
      // The external ALU output is deliberately ignored for the illegal opcode.
      if (cap_ill) begin
        rsp_result <= '0;
        rsp_flags  <= '0;
        rsp_tag    <= cur_tag;
        rsp_err    <= 1'b1;
      end
      if (mul_start) begin
        acc     <= '0;
        mul_idx <= '0;
      end
      if (mul_step) begin
        acc     <= acc_nxt;
        mul_idx <= mul_idx + IDX_W'(1);
      end
      if (mul_done) begin
        rsp_result <= acc_nxt[DATA_W-1:0];
        rsp_flags  <= mul_flags;
        rsp_tag    <= cur_tag;
        rsp_err    <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_alu_issuer.sv
// Directed bench for alu_issuer with a behavioural external ALU.
module tb_alu_issuer;
  import alu_pkg::*;

  localparam int TAG_W = 4;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             cmd_valid;
  logic             cmd_ready;
  logic [2:0]       cmd_opcode;
  logic [15:0]      cmd_a;
  logic [15:0]      cmd_b;
  logic [TAG_W-1:0] cmd_tag;
  logic [15:0]      alu_a;
  logic [15:0]      alu_b;
  logic [2:0]       alu_opcode;
  logic [15:0]      alu_result;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [15:0]      rsp_result;
  logic [1:0]       rsp_flags;
  logic [TAG_W-1:0] rsp_tag;
  logic             rsp_err;
  logic             busy;

  int checks   = 0;
  int failures = 0;

  logic [2:0]  bb_op  [5];
  logic [15:0] bb_a   [5];
  logic [15:0] bb_b   [5];
  logic [15:0] bb_res [5];

  always #5 clk = ~clk;

  alu_issuer #(.FIFO_DEPTH(4), .TAG_W(TAG_W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_opcode (cmd_opcode),
    .cmd_a      (cmd_a),
    .cmd_b      (cmd_b),
    .cmd_tag    (cmd_tag),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_opcode (alu_opcode),
    .alu_result (alu_result),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_result (rsp_result),
    .rsp_flags  (rsp_flags),
    .rsp_tag    (rsp_tag),
    .rsp_err    (rsp_err),
    .busy       (busy)
  );

  // External ALU; illegal opcode drives a marker value that must never reach rsp_result.
  always_comb begin
    case (alu_opcode)
      3'b000:  alu_result = alu_a + alu_b;
      3'b001:  alu_result = alu_a - alu_b;
      3'b010:  alu_result = alu_a & alu_b;
      3'b011:  alu_result = alu_a | alu_b;
      3'b100:  alu_result = alu_a ^ alu_b;
      3'b101:  alu_result = ~alu_a;
      3'b110:  alu_result = alu_a * alu_b;
      default: alu_result = 16'hDEAD;
    endcase
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
      $error("check %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b,
                      input logic [TAG_W-1:0] tag);
    cmd_valid  = 1'b1;
    cmd_opcode = op;
    cmd_a      = a;
    cmd_b      = b;
    cmd_tag    = tag;
    @(posedge clk);
    #1;
    cmd_valid  = 1'b0;
  endtask

  task automatic wait_rsp(output int n);
    n = 0;
    while (rsp_valid !== 1'b1 && n < 40) begin
      @(posedge clk);
      #1;
      n++;
    end
  endtask

  task automatic do_op(input string name, input logic [2:0] op, input logic [15:0] a,
                       input logic [15:0] b, input logic [TAG_W-1:0] tag,
                       input logic [15:0] exp_res, input logic [1:0] exp_flags,
                       input logic exp_err, input int exp_lat);
    int n;
    push(op, a, b, tag);
    wait_rsp(n);
    chk({name, "_lat"},   n,          exp_lat);
    chk({name, "_res"},   rsp_result, exp_res);
    chk({name, "_flags"}, rsp_flags,  exp_flags);
    chk({name, "_tag"},   rsp_tag,    tag);
    chk({name, "_err"},   rsp_err,    exp_err);
    @(posedge clk);
    #1;
    chk({name, "_hold_vld"}, rsp_valid,  1'b1);
    chk({name, "_hold_res"}, rsp_result, exp_res);
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    rsp_ready = 1'b0;
    chk({name, "_drop"},     rsp_valid,  1'b0);
    chk({name, "_keep_res"}, rsp_result, exp_res);
    chk({name, "_alu_a"},    alu_a,      a);
    chk({name, "_alu_op"},   alu_opcode, op);
  endtask

  initial begin
    int n;
    int seen;

    rst_n      = 1'b0;
    cmd_valid  = 1'b0;
    cmd_opcode = 3'b000;
    cmd_a      = '0;
    cmd_b      = '0;
    cmd_tag    = '0;
    rsp_ready  = 1'b0;

    repeat (2) @(posedge clk);
    #1;
    chk("rst_cmd_ready", cmd_ready,  1'b0);
    chk("rst_rsp_valid", rsp_valid,  1'b0);
    chk("rst_busy",      busy,       1'b0);
    chk("rst_alu_a",     alu_a,      16'h0000);
    chk("rst_alu_b",     alu_b,      16'h0000);
    chk("rst_alu_op",    alu_opcode, 3'b000);
    chk("rst_rsp_res",   rsp_result, 16'h0000);
    chk("rst_rsp_flags", rsp_flags,  2'b00);
    chk("rst_rsp_tag",   rsp_tag,    4'h0);
    chk("rst_rsp_err",   rsp_err,    1'b0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("post_rst_cmd_ready", cmd_ready, 1'b1);

    do_op("add_carry", 3'b000, 16'hFFFF, 16'h0001, 4'd3, 16'h0000, 2'b01, 1'b0, 2);
    do_op("add_ovf",   3'b000, 16'h7FFF, 16'h0001, 4'd4, 16'h8000, 2'b10, 1'b0, 2);
    do_op("sub_ovf",   3'b001, 16'h8000, 16'h0001, 4'd5, 16'h7FFF, 2'b10, 1'b0, 2);
    do_op("sub_brw",   3'b001, 16'h0001, 16'h0002, 4'd6, 16'hFFFF, 2'b01, 1'b0, 2);
    do_op("mul_hi",    3'b110, 16'h0100, 16'h0100, 4'd7, 16'h0000, 2'b01, 1'b0, 18);
    do_op("mul_small", 3'b110, 16'h0003, 16'h0005, 4'd8, 16'h000F, 2'b00, 1'b0, 18);
    do_op("illegal",   3'b111, 16'h1234, 16'h5678, 4'd9, 16'h0000, 2'b00, 1'b1, 2);
    do_op("and",       3'b010, 16'hF0F0, 16'h0FF0, 4'd10, 16'h00F0, 2'b00, 1'b0, 2);
    do_op("or",        3'b011, 16'h00FF, 16'h0F00, 4'd11, 16'h0FFF, 2'b00, 1'b0, 2);
    do_op("xor",       3'b100, 16'hFFFF, 16'h0F0F, 4'd12, 16'hF0F0, 2'b00, 1'b0, 2);
    do_op("not",       3'b101, 16'h00FF, 16'h1234, 4'd13, 16'hFF00, 2'b00, 1'b0, 2);
    chk("idle_busy", busy, 1'b0);

    // Five back-to-back commands with the consumer stalled.
    bb_op[0] = 3'b000; bb_a[0] = 16'h0001; bb_b[0] = 16'h0010; bb_res[0] = 16'h0011;
    bb_op[1] = 3'b001; bb_a[1] = 16'h0020; bb_b[1] = 16'h0002; bb_res[1] = 16'h001E;
    bb_op[2] = 3'b100; bb_a[2] = 16'h0033; bb_b[2] = 16'h000F; bb_res[2] = 16'h003C;
    bb_op[3] = 3'b110; bb_a[3] = 16'h0004; bb_b[3] = 16'h0005; bb_res[3] = 16'h0014;
    bb_op[4] = 3'b011; bb_a[4] = 16'h0050; bb_b[4] = 16'h0005; bb_res[4] = 16'h0055;
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("bb_ready_%0d", i), cmd_ready, 1'b1);
      push(bb_op[i], bb_a[i], bb_b[i], 4'(i + 1));
    end
    chk("bb_full_ready", cmd_ready, 1'b0);
    chk("bb_busy",       busy,      1'b1);
    wait_rsp(n);
    chk("bb_first_vld", rsp_valid, 1'b1);
    repeat (3) @(posedge clk);
    #1;
    chk("bb_stall_vld", rsp_valid,  1'b1);
    chk("bb_stall_tag", rsp_tag,    4'd1);
    chk("bb_stall_res", rsp_result, bb_res[0]);
    chk("bb_stall_rdy", cmd_ready,  1'b0);
    for (int i = 0; i < 5; i++) begin
      wait_rsp(n);
      chk($sformatf("bb_vld_%0d", i), rsp_valid,  1'b1);
      chk($sformatf("bb_tag_%0d", i), rsp_tag,    4'(i + 1));
      chk($sformatf("bb_res_%0d", i), rsp_result, bb_res[i]);
      rsp_ready = 1'b1;
      @(posedge clk);
      #1;
      rsp_ready = 1'b0;
    end
    chk("bb_done_busy",  busy,      1'b0);
    chk("bb_done_ready", cmd_ready, 1'b1);

    // Reset during the multiply with two commands still queued.
    push(3'b110, 16'h0003, 16'h0005, 4'd7);
    push(3'b000, 16'h0001, 16'h0001, 4'd8);
    push(3'b000, 16'h0002, 16'h0002, 4'd9);
    repeat (7) @(posedge clk);
    #1;
    chk("mrst_pre_busy", busy,      1'b1);
    chk("mrst_pre_vld",  rsp_valid, 1'b0);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    chk("mrst_busy",  busy,      1'b0);
    chk("mrst_vld",   rsp_valid, 1'b0);
    chk("mrst_ready", cmd_ready, 1'b0);
    chk("mrst_alu_a", alu_a,     16'h0000);
    rst_n     = 1'b1;
    rsp_ready = 1'b1;
    seen      = 0;
    repeat (30) begin
      @(posedge clk);
      #1;
      if (rsp_valid === 1'b1) seen++;
    end
    rsp_ready = 1'b0;
    chk("mrst_no_rsp",    seen, 0);
    chk("mrst_idle_busy", busy, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/alu_issuer.md
ALU_ISSUER -- requirements
Module: alu_issuer

Interface
REQ-001 Parameter: FIFO_DEPTH, default 4, command FIFO entries (power of two, >=2).
REQ-002 Parameter: TAG_W, default 4, width of command/response tag.
REQ-003 clk  input  1  single clock; all state on rising edge.
REQ-004 rst_n  input  1  reset, synchronous, active-low.
REQ-005 cmd_valid  input  1  command offered.
REQ-006 cmd_ready  output  1  command FIFO not full.
REQ-007 cmd_opcode  input  3  000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 101 NOT, 110 MUL, 111 illegal.
REQ-008 cmd_a / cmd_b  input  16 each  operands.
REQ-009 cmd_tag  input  TAG_W  opaque ID returned with response.
REQ-010 alu_a / alu_b  output  16 each  operands to external combinational ALU.
REQ-011 alu_opcode  output  3  opcode to external ALU.
REQ-012 alu_result  input  16  combinational ALU result, valid same cycle as alu_* outputs.
REQ-013 rsp_valid  output  1  response held valid.
REQ-014 rsp_ready  input  1  response consumer ready.
REQ-015 rsp_result  output  16  operation result.
REQ-016 rsp_flags  output  2  status flags (REQ-027).
REQ-017 rsp_tag  output  TAG_W  tag of the command.
REQ-018 rsp_err  output  1  illegal opcode.
REQ-019 busy  output  1  high when FIFO non-empty or state != IDLE.

Function
REQ-020 Push on cmd_valid && cmd_ready; cmd_ready = !full, no same-cycle pass-through when full, even if a pop occurs.
REQ-021 FSM states IDLE, ISSUE, MUL, RESP; one command in flight; strict FIFO order.
REQ-022 IDLE: FIFO non-empty -> pop, load alu_a/alu_b/alu_opcode and tag registers, go ISSUE; else stay.
REQ-023 ISSUE, opcodes 000-101: capture alu_result into rsp_result, compute flags, go RESP.
REQ-024 ISSUE, opcode 110: clear 32-bit accumulator, go MUL; MUL performs one shift-add step per cycle for exactly 16 cycles, then rsp_result = product[15:0], go RESP.
REQ-025 ISSUE, opcode 111: rsp_result = 0, rsp_flags = 00, rsp_err = 1, go RESP; ALU result ignored.
REQ-026 RESP: rsp_valid = 1, all rsp_* stable until rsp_ready; on rsp_valid && rsp_ready go IDLE, rsp_valid low next cycle.
REQ-027 Flags: ADD {signed overflow, carry out of 17-bit sum}; SUB {signed overflow, borrow = A<B unsigned}; MUL {0, product[31:16] != 0}; AND/OR/XOR/NOT 00.
REQ-028 Latency, empty FIFO, idle FSM, push at edge N: alu_* valid in cycle N+2; rsp_valid in cycle N+3 (non-MUL) or N+19 (MUL).
REQ-029 alu_* outputs hold last issued values outside ISSUE/MUL; rsp_* hold last values when rsp_valid = 0.
REQ-030 FIFO pointers wrap modulo FIFO_DEPTH; count range 0..FIFO_DEPTH; simultaneous push and pop keeps count unchanged.
REQ-031 Arithmetic modulo 2^16 on rsp_result; all operands unsigned except signed-overflow flag.

Reset
REQ-032 rst_n low at a clock edge: state IDLE, FIFO empty, pointers 0, accumulator 0, rsp_valid 0, rsp_result 0, rsp_flags 00, rsp_tag 0, rsp_err 0, alu_a/alu_b 0, alu_opcode 000, busy 0, cmd_ready 0 while rst_n low, 1 the cycle after release.
REQ-033 Reset mid-operation (any state) discards in-flight command and FIFO contents; no response is produced for them.

Structure
REQ-034 Package alu_pkg holds opcode enum, FSM state enum, DATA_W = 16, flag bit positions, MUL_CYCLES = 16.
REQ-035 Command FIFO is a sub-module alu_cmd_fifo (parameterised depth/width, synchronous active-low reset).
REQ-036 The ALU itself is external; alu_issuer does not instantiate it.

Verification
REQ-037 ADD A=0xFFFF B=0x0001 tag 3 -> rsp_result 0x0000, flags 01, tag 3, rsp_valid in cycle N+3.
REQ-038 SUB A=0x8000 B=0x0001 -> rsp_result 0x7FFF, flags 10; SUB A=0x0001 B=0x0002 -> 0xFFFF, flags 01.
REQ-039 MUL A=0x0100 B=0x0100 -> rsp_result 0x0000, flags 01, rsp_valid in cycle N+19; MUL 0x0003*0x0005 -> 0x000F, flags 00.
REQ-040 Five back-to-back commands, rsp_ready held 0 -> cmd_ready low after 4 pushes (plus one in flight), responses emerge in tag order once rsp_ready = 1, rsp_* stable while stalled.
REQ-041 Opcode 111 -> rsp_err 1, rsp_result 0x0000; next command (AND 0xF0F0, 0x0FF0) -> 0x00F0, rsp_err 0.
REQ-042 rst_n low during MUL cycle 8 with 2 commands queued -> no responses, busy 0 and rsp_valid 0 after the reset edge.
